// File: rtl/router_1xn_if.sv
// Byte-serial packet port and per-channel read side of the 1xN router.
// Handshake: a word moves on a rising edge when the source presents it and busy is low; busy is the inverse of ready.
interface router_1xn_if #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 3
);
    logic                     pkt_valid;
    logic [DATA_W-1:0]        data_in;
    logic                     busy;
    logic [N_CH-1:0]          read_en;
    logic [N_CH*DATA_W-1:0]   data_out;
    logic [N_CH-1:0]          vld_out;
    logic                     err_parity;
    logic                     err_len;
    logic                     drop;
    logic [N_CH-1:0]          flush;

    modport master (
        output pkt_valid, data_in, read_en,
        input  busy, data_out, vld_out, err_parity, err_len, drop, flush
    );

    modport slave (
        input  pkt_valid, data_in, read_en,
        output busy, data_out, vld_out, err_parity, err_len, drop, flush
    );
endinterface

// File: rtl/router_1xn.sv
// 1xN packet router: header decode, per-channel FIFOs, parity/length check,
// invalid-address drop and per-channel read-timeout flush.
module router_1xn #(
    parameter int DATA_W  = 8,
    parameter int N_CH    = 3,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 30
) (
    input  logic        clk,
    input  logic        rst,
    router_1xn_if.slave bus,
    output logic [1:0]  fsm_state
);
    localparam int ADDR_W = (N_CH > 2) ? $clog2(N_CH) : 1;
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TO_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W:0]   N_CH_V  = (ADDR_W + 1)'(N_CH);
    localparam logic [CNT_W-1:0]  FULL_V  = CNT_W'(DEPTH);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [N_CH-1:0]   ONE     = {{(N_CH - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_EMPTY = 2'd1, LOAD = 2'd2, DROP = 2'd3} state_t;
    state_t state, state_nx;

    logic [ADDR_W-1:0] tgt, hdr_addr;
    logic [DATA_W-1:0] hold_q, par_q, hdr_word, wr_data;
    logic [LEN_W-1:0]  len_q, pcnt_q;
    logic [N_CH-1:0]   empty, full, flush_now, push;
    logic              hdr_bad, tgt_full, tgt_empty, tgt_flush;
    logic              wr_en, start, fold, chk, drop_now, hold_ld, tgt_ld;

    assign hdr_addr  = bus.data_in[ADDR_W-1:0];
    assign hdr_bad   = {1'b0, hdr_addr} >= N_CH_V;
    assign tgt_full  = full[tgt];
    assign tgt_empty = empty[tgt];
    assign tgt_flush = flush_now[tgt];
    assign hdr_word  = (state == WAIT_EMPTY) ? hold_q : bus.data_in;
    assign wr_data   = hdr_word;
    assign push      = wr_en ? (ONE << ((state == IDLE) ? hdr_addr : tgt)) : '0;
    assign fsm_state = state;

    always_comb begin
        bus.busy = 1'b0;
        case (state)
            WAIT_EMPTY: bus.busy = 1'b1;
            LOAD:       bus.busy = tgt_full;
            default:    bus.busy = 1'b0;
        endcase
    end

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        start    = 1'b0;
        fold     = 1'b0;
        chk      = 1'b0;
        drop_now = 1'b0;
        hold_ld  = 1'b0;
        tgt_ld   = 1'b0;
        case (state)
            IDLE: if (bus.pkt_valid) begin
                if (hdr_bad) begin
                    state_nx = DROP;
                end else if (empty[hdr_addr]) begin
                    wr_en = 1'b1; start = 1'b1; tgt_ld = 1'b1; state_nx = LOAD;
                end else begin
                    hold_ld = 1'b1; tgt_ld = 1'b1; state_nx = WAIT_EMPTY;
                end
            end
            WAIT_EMPTY: begin
                if (tgt_flush) state_nx = DROP;
                else if (tgt_empty) begin
                    wr_en = 1'b1; start = 1'b1; state_nx = LOAD;
                end
            end
            LOAD: begin
                // A flush of the target abandons the packet; a parity word on that same edge ends it.
                if (tgt_flush) begin
                    if (!tgt_full && !bus.pkt_valid) begin
                        drop_now = 1'b1; state_nx = IDLE;
                    end else state_nx = DROP;
                end else if (!tgt_full) begin
                    wr_en = 1'b1;
                    if (bus.pkt_valid) fold = 1'b1;
                    else begin
                        chk = 1'b1; state_nx = IDLE;
                    end
                end
            end
            DROP: if (!bus.pkt_valid) begin
                drop_now = 1'b1; state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            tgt            <= '0;
            hold_q         <= '0;
            par_q          <= '0;
            len_q          <= '0;
            pcnt_q         <= '0;
            bus.err_parity <= 1'b0;
            bus.err_len    <= 1'b0;
            bus.drop       <= 1'b0;
        end else begin
            state    <= state_nx;
            bus.drop <= drop_now;
            if (tgt_ld)  tgt    <= hdr_addr;
            if (hold_ld) hold_q <= bus.data_in;
            if (start) begin
                par_q          <= hdr_word;
                len_q          <= hdr_word[DATA_W-1:ADDR_W];
                pcnt_q         <= '0;
                bus.err_parity <= 1'b0;
                bus.err_len    <= 1'b0;
            end
            if (fold) begin
                par_q  <= par_q ^ bus.data_in;
                pcnt_q <= pcnt_q + 1'b1;
            end
            if (chk) begin
                bus.err_parity <= (par_q != bus.data_in);
                bus.err_len    <= (pcnt_q != len_q);
            end
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr, rd_ptr;
        logic [CNT_W-1:0]  count;
        logic [TO_W-1:0]   to_cnt;
        logic [DATA_W-1:0] dout_q;
        logic              flush_q, pop;

        assign empty[i]     = (count == '0);
        assign full[i]      = (count == FULL_V);
        assign pop          = bus.read_en[i] && !empty[i];
        assign flush_now[i] = !empty[i] && !bus.read_en[i] && (to_cnt == TO_LAST);
        assign bus.vld_out[i]                    = !empty[i];
        assign bus.flush[i]                      = flush_q;
        assign bus.data_out[i*DATA_W +: DATA_W] = dout_q;

        always_ff @(posedge clk) begin
            if (push[i]) mem[wr_ptr] <= wr_data;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                to_cnt  <= '0;
                dout_q  <= '0;
                flush_q <= 1'b0;
            end else begin
                flush_q <= flush_now[i];
                if (flush_now[i]) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    count  <= '0;
                    to_cnt <= '0;
                    dout_q <= '0;
                end else begin
                    if (push[i]) wr_ptr <= wr_ptr + 1'b1;
                    if (pop) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        dout_q <= mem[rd_ptr];
                    end
                    count <= count + CNT_W'(push[i]) - CNT_W'(pop);
                    if (!empty[i] && !bus.read_en[i]) to_cnt <= to_cnt + 1'b1;
                    else                              to_cnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_router_1xn.sv
// Self-checking bench for router_1xn: scoreboard queue of words expected out of the channel under test.
module tb_router_1xn;
  localparam int DATA_W  = 8;
  localparam int N_CH    = 3;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] fsm_state;

  router_1xn_if #(.DATA_W(DATA_W), .N_CH(N_CH)) bus ();

  router_1xn #(.DATA_W(DATA_W), .N_CH(N_CH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int drop_cnt = 0;
  int flush2_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  always @(posedge clk) begin
    if (bus.drop === 1'b1) drop_cnt++;
    if (bus.flush[2] === 1'b1) flush2_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] dout(input int ch);
    return bus.data_out[ch*DATA_W +: DATA_W];
  endfunction

  // Presents one word, waits (bounded) for busy low, returns 1 time unit after the accepting edge.
  task automatic send_word(input logic [7:0] d, input logic pv, input bit store);
    int waits = 0;
    bus.data_in = d;
    bus.pkt_valid = pv;
    @(negedge clk);
    while (bus.busy === 1'b1 && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (bus.busy !== 1'b0) begin
      checks++; errors++;
      $display("FAIL send_busy_timeout: busy=%b still high after %0d cycles, required 0", bus.busy, waits);
    end
    if (store) exp_q.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input int ch, input int len, input int n, input logic [7:0] seed,
                          input bit corrupt, input bit store);
    logic [7:0] hdr, par, w;
    hdr = 8'((len << 2) | ch);
    par = hdr;
    send_word(hdr, 1'b1, store);
    for (int k = 0; k < n; k++) begin
      w = seed + 8'(k * 17);
      par ^= w;
      send_word(w, 1'b1, store);
    end
    send_word(corrupt ? ~par : par, 1'b0, store);
  endtask

  task automatic pop_check(input int ch, input string tag);
    logic [7:0] exp;
    bus.read_en[ch] = 1'b1;
    @(posedge clk); #1;
    bus.read_en[ch] = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", tag, dout(ch));
    end else begin
      exp = exp_q.pop_front();
      if (dout(ch) !== exp) begin
        errors++;
        $display("FAIL %s: ch%0d data_out=%h required %h", tag, ch, dout(ch), exp);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    checks++; if (bus.vld_out !== 3'b000) begin errors++; $display("FAIL reset_vld: got %b required 000", bus.vld_out); end
    checks++; if (bus.data_out !== 24'h0) begin errors++; $display("FAIL reset_data: got %h required 0", bus.data_out); end
    checks++; if ({bus.err_parity, bus.err_len, bus.drop} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b required 000", {bus.err_parity, bus.err_len, bus.drop}); end
    checks++; if (bus.flush !== 3'b000 || fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: flush=%b state=%0d required 000/0", bus.flush, fsm_state); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    // header 0x0D = addr 1, len 3; parity is the XOR of header and payload (0x0D)
    send_pkt(1, 3, 3, 8'h11, 1'b0, 1'b1);
    checks++; if (bus.vld_out !== 3'b010) begin errors++; $display("FAIL single_vld: got %b required 010", bus.vld_out); end
    checks++; if ({bus.err_parity, bus.err_len} !== 2'b00) begin errors++; $display("FAIL single_err: got %b required 00", {bus.err_parity, bus.err_len}); end
    for (int k = 0; k < 5; k++) pop_check(1, "single_pop");
    bus.read_en[1] = 1'b1;
    @(posedge clk); #1;
    bus.read_en[1] = 1'b0;
    checks++; if (dout(1) !== 8'h0D || bus.vld_out !== 3'b000) begin errors++; $display("FAIL empty_read: data=%h vld=%b required 0d/000", dout(1), bus.vld_out); end
  endtask

  task automatic test_bad;
    send_pkt(1, 3, 2, 8'h11, 1'b1, 1'b1);
    checks++; if (bus.err_parity !== 1'b1) begin errors++; $display("FAIL bad_parity: got %b required 1", bus.err_parity); end
    checks++; if (bus.err_len !== 1'b1) begin errors++; $display("FAIL bad_len: got %b required 1", bus.err_len); end
    for (int k = 0; k < 4; k++) pop_check(1, "bad_pop");
    send_word(8'h04, 1'b1, 1'b1);
    checks++; if ({bus.err_parity, bus.err_len} !== 2'b00) begin errors++; $display("FAIL err_clear: got %b required 00", {bus.err_parity, bus.err_len}); end
    send_word(8'hA5, 1'b1, 1'b1);
    send_word(8'h04 ^ 8'hA5, 1'b0, 1'b1);
    checks++; if ({bus.err_parity, bus.err_len} !== 2'b00) begin errors++; $display("FAIL good_after_bad: got %b required 00", {bus.err_parity, bus.err_len}); end
    for (int k = 0; k < 3; k++) pop_check(0, "good_pop");
  endtask

  task automatic test_backpressure;
    logic [7:0] par, w;
    par = 8'h20;
    send_word(8'h20, 1'b1, 1'b1);
    for (int k = 0; k < 7; k++) begin
      w = 8'h30 + 8'(k);
      par ^= w;
      send_word(w, 1'b1, 1'b1);
    end
    w = 8'h37;
    par ^= w;
    bus.data_in = w; bus.pkt_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.vld_out[0] !== 1'b1) begin errors++; $display("FAIL bp_full: busy=%b vld0=%b required 1/1", bus.busy, bus.vld_out[0]); end
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_hold: busy=%b required 1", bus.busy); end
    pop_check(0, "bp_pop");
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_window: busy=%b required 0", bus.busy); end
    exp_q.push_back(w);
    @(posedge clk); #1;
    bus.data_in = par; bus.pkt_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bp_refull: busy=%b required 1", bus.busy); end
    pop_check(0, "bp_pop2");
    exp_q.push_back(par);
    @(posedge clk); #1;
    checks++; if (fsm_state !== 2'd0 || {bus.err_parity, bus.err_len} !== 2'b00) begin errors++; $display("FAIL bp_end: state=%0d err=%b required 0/00", fsm_state, {bus.err_parity, bus.err_len}); end
    for (int k = 0; k < 8; k++) pop_check(0, "bp_drain");
    checks++; if (bus.vld_out[0] !== 1'b0) begin errors++; $display("FAIL bp_empty: vld0=%b required 0", bus.vld_out[0]); end
  endtask

  task automatic test_wait_empty;
    send_pkt(0, 1, 1, 8'h55, 1'b0, 1'b1);
    bus.data_in = 8'h04; bus.pkt_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL we_idle: busy=%b required 0", bus.busy); end
    exp_q.push_back(8'h04);
    @(posedge clk); #1;
    bus.data_in = 8'h66;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || fsm_state !== 2'd1) begin errors++; $display("FAIL we_enter: busy=%b state=%0d required 1/1", bus.busy, fsm_state); end
    for (int k = 0; k < 3; k++) begin
      pop_check(0, "we_drain");
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL we_busy: busy=%b required 1", bus.busy); end
    end
    @(posedge clk); #1;
    checks++; if (bus.busy !== 1'b0 || fsm_state !== 2'd2) begin errors++; $display("FAIL we_load: busy=%b state=%0d required 0/2", bus.busy, fsm_state); end
    send_word(8'h66, 1'b1, 1'b1);
    send_word(8'h04 ^ 8'h66, 1'b0, 1'b1);
    checks++; if ({bus.err_parity, bus.err_len} !== 2'b00) begin errors++; $display("FAIL we_err: got %b required 00", {bus.err_parity, bus.err_len}); end
    for (int k = 0; k < 3; k++) pop_check(0, "we_pop");
  endtask

  task automatic test_invalid;
    int d0;
    d0 = drop_cnt;
    send_word(8'h0B, 1'b1, 1'b0);
    checks++; if (fsm_state !== 2'd3 || bus.busy !== 1'b0) begin errors++; $display("FAIL inv_drop_state: state=%0d busy=%b required 3/0", fsm_state, bus.busy); end
    send_word(8'h12, 1'b1, 1'b0);
    send_word(8'h34, 1'b1, 1'b0);
    checks++; if (bus.drop !== 1'b0) begin errors++; $display("FAIL inv_early_drop: drop=%b required 0", bus.drop); end
    send_word(8'h0B ^ 8'h12 ^ 8'h34, 1'b0, 1'b0);
    checks++; if (bus.drop !== 1'b1 || bus.vld_out !== 3'b000 || fsm_state !== 2'd0) begin errors++; $display("FAIL inv_pulse: drop=%b vld=%b state=%0d required 1/000/0", bus.drop, bus.vld_out, fsm_state); end
    @(posedge clk); #1;
    checks++; if (bus.drop !== 1'b0 || drop_cnt !== d0 + 1) begin errors++; $display("FAIL inv_once: drop=%b pulses=%0d required 0/1", bus.drop, drop_cnt - d0); end
  endtask

  task automatic test_timeout;
    int c;
    send_pkt(2, 1, 1, 8'h77, 1'b0, 1'b1);
    pop_check(2, "to_pop");
    c = 0;
    while (c < 60 && bus.flush[2] !== 1'b1) begin
      @(posedge clk); #1;
      c++;
    end
    checks++; if (c !== TIMEOUT) begin errors++; $display("FAIL to_cycle: flush after %0d cycles required %0d", c, TIMEOUT); end
    checks++; if (bus.flush !== 3'b100 || bus.vld_out[2] !== 1'b0) begin errors++; $display("FAIL to_flush: flush=%b vld2=%b required 100/0", bus.flush, bus.vld_out[2]); end
    checks++; if (dout(2) !== 8'h00) begin errors++; $display("FAIL to_data: slice2=%h required 00", dout(2)); end
    @(posedge clk); #1;
    checks++; if (bus.flush !== 3'b000) begin errors++; $display("FAIL to_pulse: flush=%b required 000", bus.flush); end
    exp_q.delete();
  endtask

  task automatic test_timeout_midpkt;
    int d0, f0;
    logic [7:0] par;
    d0 = drop_cnt;
    f0 = flush2_cnt;
    par = 8'hA2;
    send_word(8'hA2, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      par ^= 8'(k);
      send_word(8'(k), 1'b1, 1'b0);
    end
    send_word(par, 1'b0, 1'b0);
    checks++; if (bus.drop !== 1'b1 || fsm_state !== 2'd0) begin errors++; $display("FAIL tm_drop: drop=%b state=%0d required 1/0", bus.drop, fsm_state); end
    @(posedge clk); #1;
    checks++; if (drop_cnt !== d0 + 1 || flush2_cnt !== f0 + 1) begin errors++; $display("FAIL tm_counts: drops=%0d flushes=%0d required 1/1", drop_cnt - d0, flush2_cnt - f0); end
    checks++; if (bus.vld_out !== 3'b000) begin errors++; $display("FAIL tm_vld: vld=%b required 000", bus.vld_out); end
  endtask

  task automatic test_reset_midpkt;
    send_word(8'h0C, 1'b1, 1'b0);
    send_word(8'h99, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.vld_out !== 3'b000) begin errors++; $display("FAIL rm_flags: busy=%b vld=%b required 0/000", bus.busy, bus.vld_out); end
    checks++; if (bus.data_out !== 24'h0 || fsm_state !== 2'd0) begin errors++; $display("FAIL rm_state: data=%h state=%0d required 0/0", bus.data_out, fsm_state); end
    bus.pkt_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    send_pkt(0, 2, 2, 8'h3C, 1'b0, 1'b1);
    checks++; if ({bus.err_parity, bus.err_len} !== 2'b00 || bus.vld_out !== 3'b001) begin errors++; $display("FAIL rm_next: err=%b vld=%b required 00/001", {bus.err_parity, bus.err_len}, bus.vld_out); end
    for (int k = 0; k < 4; k++) pop_check(0, "rm_pop");
  endtask

  task automatic test_random;
    int ch, n;
    logic [7:0] seed;
    logic [2:0] expv;
    for (int p = 0; p < 6; p++) begin
      ch   = $urandom_range(0, 2);
      n    = $urandom_range(0, 5);
      seed = 8'($urandom_range(0, 255));
      expv = 3'b001 << ch;
      send_pkt(ch, n, n, seed, 1'b0, 1'b1);
      checks++; if ({bus.err_parity, bus.err_len} !== 2'b00 || bus.vld_out !== expv) begin errors++; $display("FAIL rand_pkt: err=%b vld=%b required 00/%b", {bus.err_parity, bus.err_len}, bus.vld_out, expv); end
      for (int k = 0; k < n + 2; k++) pop_check(ch, "rand_pop");
    end
  endtask

  initial begin
    bus.pkt_valid = 1'b0;
    bus.data_in   = '0;
    bus.read_en   = '0;
    test_reset();
    test_single();
    test_bad();
    test_backpressure();
    test_wait_empty();
    test_invalid();
    test_timeout();
    test_timeout_midpkt();
    test_reset_midpkt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
